// File: rtl/game_flow_if.sv
// game_flow_if: engine events in, session controls out, between the game engine and the flow controller.
interface game_flow_if #(
  parameter int LIFE_W  = 3,
  parameter int LEVEL_W = 3
);
  logic               frame_tick;
  logic               start_btn;
  logic               pause_btn;
  logic               collision;
  logic               level_done;
  logic               timer_expired;
  logic [2:0]         state;
  logic [LIFE_W-1:0]  lives;
  logic [LEVEL_W-1:0] level;
  logic               run_en;
  logic               load_level;
  logic               end_game;
  modport master (
    output frame_tick, start_btn, pause_btn, collision, level_done, timer_expired,
    input  state, lives, level, run_en, load_level, end_game
  );
  modport slave (
    input  frame_tick, start_btn, pause_btn, collision, level_done, timer_expired,
    output state, lives, level, run_en, load_level, end_game
  );
endinterface

// File: rtl/game_flow_controller.sv
// game_flow_controller: game session sequencer owning lives/level counters and datapath run/reload/end controls.
module game_flow_controller #(
  parameter int LIVES_INIT   = 3,
  parameter int LIFE_W       = 3,
  parameter int MAX_LEVEL    = 4,
  parameter int LEVEL_W      = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int CNT_W        = 8
) (
  input logic       clk,
  input logic       rst_n,
  game_flow_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PLAY, PAUSE, HIT, LEVEL_UP, WIN, LOSE} state_t;
  localparam logic [LIFE_W-1:0]  LIVES_START = LIFE_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(MAX_LEVEL);
  localparam logic [CNT_W-1:0]   DELAY       = CNT_W'(PAUSE_FRAMES);
  state_t             state, nextState;
  logic [LIFE_W-1:0]  lives, nextLives;
  logic [LEVEL_W-1:0] level, nextLevel;
  logic [CNT_W-1:0]   cnt, nextCnt;
  logic               nextLoad, loadLevel, runEn, endGame;
  always_comb begin
    nextState = state;
    nextLives = lives;
    nextLevel = level;
    nextCnt   = cnt;
    nextLoad  = 1'b0;
    case (state)
      IDLE: if (bus.start_btn) begin
        nextState = PLAY;
        nextLives = LIVES_START;
        nextLevel = LEVEL_W'(1);
        nextLoad  = 1'b1;
      end
      PLAY: begin
        // fixed priority; losing events beat everything, lower ones are dropped
        if (bus.timer_expired) nextState = LOSE;
        else if (bus.collision) begin
          nextState = (lives <= LIFE_W'(1)) ? LOSE : HIT;
          nextLives = (lives <= LIFE_W'(1)) ? '0 : lives - LIFE_W'(1);
          nextCnt   = (lives <= LIFE_W'(1)) ? cnt : DELAY;
        end else if (bus.level_done) begin
          nextState = (level >= LAST_LEVEL) ? WIN : LEVEL_UP;
          nextLevel = (level >= LAST_LEVEL) ? level : level + LEVEL_W'(1);
          nextCnt   = (level >= LAST_LEVEL) ? cnt : DELAY;
        end else if (bus.pause_btn) nextState = PAUSE;
      end
      PAUSE: nextState = bus.pause_btn ? PLAY : PAUSE;
      HIT, LEVEL_UP: if (bus.frame_tick) begin
        // a zero count can only come from corruption; treat it as expired
        if (cnt <= CNT_W'(1)) begin
          nextState = PLAY;
          nextCnt   = '0;
          nextLoad  = 1'b1;
        end else nextCnt = cnt - CNT_W'(1);
      end
      WIN, LOSE: nextState = bus.start_btn ? IDLE : state;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lives     <= '0;
      level     <= '0;
      cnt       <= '0;
      loadLevel <= 1'b0;
      runEn     <= 1'b0;
      endGame   <= 1'b0;
    end else begin
      state     <= nextState;
      lives     <= nextLives;
      level     <= nextLevel;
      cnt       <= nextCnt;
      loadLevel <= nextLoad;
      runEn     <= nextState == PLAY;
      endGame   <= nextState == WIN || nextState == LOSE;
    end
  end
  assign bus.state      = state;
  assign bus.lives      = lives;
  assign bus.level      = level;
  assign bus.run_en     = runEn;
  assign bus.load_level = loadLevel;
  assign bus.end_game   = endGame;
endmodule

// File: tb/tb_game_flow_controller.sv
// tb_game_flow_controller: directed plus random stimulus against a session-rule model, checked through a scoreboard queue.
module tb_game_flow_controller;
  localparam int LIVES_INIT = 3, LIFE_W = 3, MAX_LEVEL = 4, LEVEL_W = 3, PF = 60, CNT_W = 8;
  typedef struct packed {
    logic [2:0]         st;
    logic [LIFE_W-1:0]  lv;
    logic [LEVEL_W-1:0] lev;
    logic               run;
    logic               load;
    logic               eg;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  game_flow_if #(.LIFE_W(LIFE_W), .LEVEL_W(LEVEL_W)) bus ();
  game_flow_controller #(
    .LIVES_INIT(LIVES_INIT), .LIFE_W(LIFE_W), .MAX_LEVEL(MAX_LEVEL),
    .LEVEL_W(LEVEL_W), .PAUSE_FRAMES(PF), .CNT_W(CNT_W)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int checks = 0, fails = 0;
  int mState = 0, mLives = 0, mLevel = 0, mCnt = 0;
  bit mLoad = 0;
  function automatic exp_t actual();
    return {bus.state, bus.lives, bus.level, bus.run_en, bus.load_level, bus.end_game};
  endfunction
  function automatic exp_t modelOut();
    exp_t e;
    e.st   = 3'(mState);
    e.lv   = LIFE_W'(mLives);
    e.lev  = LEVEL_W'(mLevel);
    e.run  = mState == 1;
    e.load = mLoad;
    e.eg   = mState == 5 || mState == 6;
    return e;
  endfunction
  function automatic void check(string name, exp_t got, exp_t want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got state=%0d lives=%0d level=%0d run=%0b load=%0b end=%0b, want state=%0d lives=%0d level=%0d run=%0b load=%0b end=%0b",
        name, $time, got.st, got.lv, got.lev, got.run, got.load, got.eg,
        want.st, want.lv, want.lev, want.run, want.load, want.eg);
    end
  endfunction
  // Session rules: 0 idle, 1 play, 2 pause, 3 hit, 4 level up, 5 win, 6 lose.
  function automatic void advance(bit ft, bit st, bit pa, bit co, bit ld, bit te);
    mLoad = 0;
    if (mState == 0 && st) begin
      mState = 1; mLives = LIVES_INIT; mLevel = 1; mLoad = 1;
    end else if (mState == 1) begin
      if (te) mState = 6;
      else if (co && mLives == 1) begin mState = 6; mLives = 0; end
      else if (co) begin mState = 3; mLives--; mCnt = PF; end
      else if (ld && mLevel == MAX_LEVEL) mState = 5;
      else if (ld) begin mState = 4; mLevel++; mCnt = PF; end
      else if (pa) mState = 2;
    end else if (mState == 2 && pa) mState = 1;
    else if ((mState == 3 || mState == 4) && ft) begin
      mCnt--;
      if (mCnt == 0) begin mState = 1; mLoad = 1; end
    end else if ((mState == 5 || mState == 6) && st) mState = 0;
  endfunction
  task automatic step(bit rn, bit ft, bit st, bit pa, bit co, bit ld, bit te);
    @(negedge clk);
    {bus.frame_tick, bus.start_btn, bus.pause_btn, bus.collision, bus.level_done, bus.timer_expired} = {ft, st, pa, co, ld, te};
    if (!rn && rst_n) begin
      rst_n = 1'b0;
      #1 check("async_reset", actual(), '0);
    end
    rst_n = rn;
    if (!rn) begin
      mState = 0; mLives = 0; mLevel = 0; mCnt = 0; mLoad = 0;
    end else advance(ft, st, pa, co, ld, te);
    q.push_back(modelOut());
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask
  // frame ticks through a respawn/level delay with stray events that must be ignored
  task automatic delay();
    for (int i = 0; i < PF; i++)
      step(1, 1, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) check("scoreboard", actual(), q.pop_front());
    end
  end
  initial begin
    {bus.frame_tick, bus.start_btn, bus.pause_btn, bus.collision, bus.level_done, bus.timer_expired} = '0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 1, 1);
    idle(2);
    step(1, 1, 0, 1, 1, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 1, 1, 0);
    delay();
    idle(2);
    step(1, 0, 0, 0, 1, 0, 0);
    delay();
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    idle(2);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 1, 0);
      delay();
      idle(1);
    end
    step(1, 0, 0, 0, 0, 1, 0);
    idle(2);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 1, 1);
    idle(2);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 999) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 99) == 0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
